instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Decouples instruction fetch from dispatch with a small circular FIFO of
// {instruction, pc} pairs. A mispredicted branch empties the buffer in one
// cycle and redirects fetch to the resolved target.
//
// Parameters
//   DEPTH  : number of buffer entries (power of two, >= 2)
//   WORD_W : width of instruction and PC words
//
// Ports
//   CLK            in   sole clock, rising edge
//   nRST           in   asynchronous active-low reset
//   fetch_valid    in   fetch presents a valid instr/pc this cycle
//   fetch_instr    in   instruction word from fetch
//   fetch_pc       in   PC of fetch_instr
//   misprediction  in   execute reports a mispredicted branch this cycle
//   correct_target in   resolved branch target, qualified by misprediction
//   dispatch_ready in   dispatch accepts the head entry this cycle
//   stall          out  buffer full: fetch must hold its instr/pc
//   flush          out  redirect fetch (mirrors misprediction)
//   flush_target   out  redirect PC (mirrors correct_target)
//   dispatch_free  out  buffer empty
//   out_valid      out  head entry valid for dispatch
//   out_instr      out  head instruction
//   out_pc         out  head PC
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              fetch_valid,
  input  logic [WORD_W-1:0] fetch_instr,
  input  logic [WORD_W-1:0] fetch_pc,
  input  logic              misprediction,
  input  logic [WORD_W-1:0] correct_target,
  input  logic              dispatch_ready,
  output logic              stall,
  output logic              flush,
  output logic [WORD_W-1:0] flush_target,
  output logic              dispatch_free,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t FULL_CNT  = cnt_t'(DEPTH);
  localparam cnt_t EMPTY_CNT = cnt_t'(0);
  localparam ptr_t LAST_PTR  = ptr_t'(DEPTH - 1);

  // Storage has no reset: validity is defined only by head/tail/count.
  word_t instr_mem_q [DEPTH];
  word_t pc_mem_q    [DEPTH];

  ptr_t head_q,  head_d;
  ptr_t tail_q,  tail_d;
  cnt_t count_q, count_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Circular pointer increment with explicit wrap at DEPTH-1.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p == LAST_PTR) begin
      r = ptr_t'(0);
    end else begin
      r = p + ptr_t'(1);
    end
    return r;
  endfunction

  // Occupancy flags and handshake qualification.
  // A misprediction blocks both directions so nothing moves in the flush cycle.
  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == EMPTY_CNT);
  assign push_s  = fetch_valid && !full_s && !misprediction;
  assign pop_s   = out_valid && dispatch_ready;

  // Fetch-side and dispatch-side outputs; head data comes straight from storage,
  // so a freshly pushed entry is only visible the cycle after its push.
  assign stall         = full_s;
  assign dispatch_free = empty_s;
  assign flush         = misprediction;
  assign flush_target  = correct_target;
  assign out_valid     = !empty_s && !misprediction;
  assign out_instr     = instr_mem_q[head_q];
  assign out_pc        = pc_mem_q[head_q];

  // Next-state computation for pointers and occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (misprediction) begin
      head_d  = ptr_t'(0);
      tail_d  = ptr_t'(0);
      count_d = EMPTY_CNT;
    end else begin
      if (push_s) begin
        tail_d = ptr_inc(tail_q);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers with asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= ptr_t'(0);
      tail_q  <= ptr_t'(0);
      count_q <= EMPTY_CNT;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write at the tail on an accepted push.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      instr_mem_q[tail_q] <= fetch_instr;
      pc_mem_q[tail_q]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        CLK;
  logic        nRST;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        misprediction;
  logic [31:0] correct_target;
  logic        dispatch_ready;
  logic        stall;
  logic        flush;
  logic [31:0] flush_target;
  logic        dispatch_free;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch_buffer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .misprediction  (misprediction),
    .correct_target (correct_target),
    .dispatch_ready (dispatch_ready),
    .stall          (stall),
    .flush          (flush),
    .flush_target   (flush_target),
    .dispatch_free  (dispatch_free),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic m, input logic [31:0] tgt, input logic r);
    @(negedge CLK);
    fetch_valid    = v;
    fetch_instr    = ins;
    fetch_pc       = pc;
    misprediction  = m;
    correct_target = tgt;
    dispatch_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST           = 1'b0;
    fetch_valid    = 1'b0;
    misprediction  = 1'b0;
    dispatch_ready = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    misprediction  = 1'b1;
    correct_target = 32'h0000_0055;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b exp 0", stall); end
    tests_run++; if (dispatch_free !== 1'b1) begin tests_failed++; $display("FAIL reset_free got %b exp 1", dispatch_free); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL reset_flush got %b exp 1", flush); end
    tests_run++; if (flush_target !== 32'h0000_0055) begin tests_failed++; $display("FAIL reset_flush_target got %h exp 00000055", flush_target); end
    misprediction = 1'b0;
    #1;
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush_low got %b exp 0", flush); end
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tests_run++; if (dispatch_free !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got free=%b ov=%b exp free=1 ov=0", dispatch_free, out_valid); end
  endtask

  task automatic test_single_push();
    do_reset();
    drive(1'b1, 32'h0000_0013, 32'h0, 1'b0, 32'h0, 1'b0);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL no_passthrough got %b exp 0", out_valid); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    tests_run++; if (out_instr !== 32'h0000_0013) begin tests_failed++; $display("FAIL single_out_instr got %h exp 00000013", out_instr); end
    tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL single_out_pc got %h exp 00000000", out_pc); end
    tests_run++; if (dispatch_free !== 1'b0) begin tests_failed++; $display("FAIL single_free got %b exp 0", dispatch_free); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'(i * 4);
      drive(1'b1, 32'h1000 + pc, pc, 1'b0, 32'h0, 1'b0);
      tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL fill_stall_%0d got %b exp 0", i, stall); end
    end
    drive(1'b1, 32'h1010, 32'h10, 1'b0, 32'h0, 1'b0);
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL full_stall got %b exp 1", stall); end
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'(i * 4);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      tests_run++; if (out_valid !== 1'b1 || out_pc !== pc || out_instr !== 32'h1000 + pc) begin
        tests_failed++; $display("FAIL drain_%0d got ov=%b pc=%h instr=%h exp ov=1 pc=%h instr=%h", i, out_valid, out_pc, out_instr, pc, 32'h1000 + pc);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tests_run++; if (out_valid !== 1'b0 || dispatch_free !== 1'b1) begin tests_failed++; $display("FAIL drained_empty got ov=%b free=%b exp ov=0 free=1", out_valid, dispatch_free); end
  endtask

  task automatic test_back_to_back();
    entry_t      q[$];
    entry_t      e;
    logic [31:0] pc;
    do_reset();
    pc = 32'h100;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ~pc, pc, 1'b0, 32'h0, 1'b0);
      q.push_back('{instr: ~pc, pc: pc});
      pc = pc + 32'h4;
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, ~pc, pc, 1'b0, 32'h0, 1'b1);
      e = q.pop_front();
      tests_run++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr || stall !== 1'b0) begin
        tests_failed++; $display("FAIL b2b_%0d got ov=%b pc=%h instr=%h stall=%b exp ov=1 pc=%h instr=%h stall=0", k, out_valid, out_pc, out_instr, stall, e.pc, e.instr);
      end
      q.push_back('{instr: ~pc, pc: pc});
      pc = pc + 32'h4;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      e = q.pop_front();
      tests_run++; if (out_valid !== 1'b1 || out_pc !== e.pc) begin tests_failed++; $display("FAIL b2b_drain_%0d got ov=%b pc=%h exp ov=1 pc=%h", i, out_valid, out_pc, e.pc); end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_count2 got ov=%b exp 0", out_valid); end
  endtask

  task automatic test_flush_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h2000 + 32'(i), 32'(i * 4), 1'b0, 32'h0, 1'b0);
    end
    drive(1'b1, 32'hDEAD_BEEF, 32'h40, 1'b1, 32'h100, 1'b1);
    tests_run++; if (flush !== 1'b1 || flush_target !== 32'h100) begin tests_failed++; $display("FAIL flush_same_cycle got flush=%b tgt=%h exp flush=1 tgt=00000100", flush, flush_target); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL flush_stall_hold got %b exp 1", stall); end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tests_run++; if (stall !== 1'b0 || dispatch_free !== 1'b1 || out_valid !== 1'b0 || flush !== 1'b0) begin
      tests_failed++; $display("FAIL flush_after got stall=%b free=%b ov=%b flush=%b exp 0 1 0 0", stall, dispatch_free, out_valid, flush);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + 32'(i), 32'(i * 4), 1'b0, 32'h0, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL premid_valid got %b exp 1", out_valid); end
    #1;
    nRST = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || dispatch_free !== 1'b1) begin tests_failed++; $display("FAIL midreset got ov=%b free=%b exp ov=0 free=1", out_valid, dispatch_free); end
    @(negedge CLK);
    nRST = 1'b1;
    drive(1'b1, 32'h0000_AAAA, 32'h20, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h0000_AAAA) begin
      tests_failed++; $display("FAIL post_midreset got ov=%b pc=%h instr=%h exp ov=1 pc=00000020 instr=0000aaaa", out_valid, out_pc, out_instr);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_midreset_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    entry_t      q[$];
    entry_t      e;
    logic        v, m, r;
    logic [31:0] ins, pc, tgt;
    logic        exp_stall, exp_ov;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      m   = ($urandom_range(0, 24) == 0);
      r   = ($urandom_range(0, 9) < 5);
      ins = $urandom;
      pc  = $urandom;
      tgt = $urandom;
      drive(v, ins, pc, m, tgt, r);
      exp_stall = (q.size() == DEPTH);
      exp_ov    = (q.size() != 0) && !m;
      tests_run++; if (stall !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, stall, exp_stall); end
      tests_run++; if (dispatch_free !== logic'(q.size() == 0)) begin tests_failed++; $display("FAIL rnd_free c=%0d got %b exp %b", c, dispatch_free, q.size() == 0); end
      tests_run++; if (flush !== m || flush_target !== tgt) begin tests_failed++; $display("FAIL rnd_flush c=%0d got %b/%h exp %b/%h", c, flush, flush_target, m, tgt); end
      tests_run++; if (out_valid !== exp_ov) begin tests_failed++; $display("FAIL rnd_out_valid c=%0d got %b exp %b", c, out_valid, exp_ov); end
      if (exp_ov) begin
        tests_run++; if (out_instr !== q[0].instr || out_pc !== q[0].pc) begin
          tests_failed++; $display("FAIL rnd_head c=%0d got %h/%h exp %h/%h", c, out_instr, out_pc, q[0].instr, q[0].pc);
        end
      end
      if (m) begin
        q.delete();
      end else begin
        if (exp_ov && r) e = q.pop_front();
        if (v && !exp_stall) q.push_back('{instr: ins, pc: pc});
      end
    end
  endtask

  initial begin
    nRST           = 1'b0;
    fetch_valid    = 1'b0;
    fetch_instr    = 32'h0;
    fetch_pc       = 32'h0;
    misprediction  = 1'b0;
    correct_target = 32'h0;
    dispatch_ready = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flush_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
